fetch_unit: RTL

Instruction fetch front end of the single-issue RV32I core; the producer side of the decoder's `i_instr` input. It issues word-aligned read requests to instruction memory and tolerates variable memory latency with up to 2 requests in flight. It buffers returned words in a 2-entry FIFO and presents them in program order, each with its PC, through a valid/ready handshake. On a branch or jump redirect it flushes the FIFO, discards stale in-flight responses and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, buffers up to two words, flushes on redirect.
// Optional misaligned-target fault state is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_req_valid,
    output logic [31:0] o_req_addr,
    input  logic        i_req_ready,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [1:0]  out_cnt;
    logic [1:0]  drop_cnt;
    logic [1:0]  cnt;
    logic [31:0] fifo [2];
    logic        rd_ptr;
    logic        wr_ptr;

    logic        run;
    logic        pop;
    logic        hs;
    logic        rsp;
    logic        drop;
    logic        keep;
    logic [2:0]  credit;
    logic [1:0]  out_nxt;
    logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic {RUN, FAULT} state_t;
    state_t state_q;
    state_t state_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_redirect)
            state_d = (i_redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
    end

    always_comb begin
        run     = (state_q == RUN);
        o_fault = (state_q == FAULT);
    end

    assign tgt = i_redirect_pc;
`else
    assign run     = 1'b1;
    assign o_fault = 1'b0;
    assign tgt     = i_redirect_pc & 32'hFFFF_FFFC;
`endif

    assign o_valid = (cnt != 2'd0);
    assign pop     = o_valid & i_ready;

    // Credit covers both in-flight requests and buffered words.
    assign credit  = {1'b0, out_cnt} + {1'b0, cnt} - {2'b00, pop};

    assign o_req_valid = !i_rst && run && (credit < 3'd2);
    assign o_req_addr  = fpc;

    assign hs      = o_req_valid & i_req_ready;
    assign rsp     = i_rsp_valid & (out_cnt != 2'd0);
    assign drop    = rsp & (drop_cnt != 2'd0);
    assign keep    = rsp & ~drop;
    assign out_nxt = out_cnt + {1'b0, hs} - {1'b0, rsp};

    assign o_instr = o_valid ? fifo[rd_ptr] : NOP;
    assign o_pc    = dpc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc      <= RESET_PC;
            dpc      <= RESET_PC;
            out_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
            cnt      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (i_redirect) begin
            fpc      <= tgt;
            dpc      <= tgt;
            cnt      <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            out_cnt  <= out_nxt;
            drop_cnt <= out_nxt;
        end else begin
            out_cnt <= out_nxt;
            cnt     <= cnt + {1'b0, keep} - {1'b0, pop};
            if (hs)   fpc      <= fpc + 32'd4;
            if (pop)  dpc      <= dpc + 32'd4;
            if (pop)  rd_ptr   <= ~rd_ptr;
            if (keep) wr_ptr   <= ~wr_ptr;
            if (drop) drop_cnt <= drop_cnt - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_redirect && keep)
            fifo[wr_ptr] <= i_rsp_data;
    end

endmodule
